// File: rtl/rr_packet_allocator.sv
// Round-robin output-port allocator: one idle cycle picks a header, then the winner owns the port for its whole packet.
// Grant is combinational from the locked owner, gated by dcts/empty/req; stalls hold owner, count and state indefinitely.
module rr_packet_allocator #(
  parameter int unsigned N_REQ     = 3,
  parameter int unsigned LEN_W     = 12,
  parameter logic [2:0]  HDR_TYPE  = 3'b001,
  parameter logic [2:0]  BODY_TYPE = 3'b010,
  parameter logic [2:0]  TAIL_TYPE = 3'b100
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ-1:0]       empty,
  input  logic [3*N_REQ-1:0]     flit_type,
  input  logic [LEN_W*N_REQ-1:0] length,
  input  logic                   dcts,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       sel,
  output logic                   busy,
  output logic                   pkt_done,
  output logic                   len_err
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic {IDLE, LOCK} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             len_gt1_q, len_gt1_d;
  logic             pkt_done_q, pkt_done_d;
  logic             len_err_q, len_err_d;

  logic [2:0]       ftype [N_REQ];
  logic [LEN_W-1:0] flen  [N_REQ];
  logic [N_REQ-1:0] cand;
  logic             found;
  logic [IDX_W-1:0] winner;
  logic             own_gnt, own_tail, last_flit;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      ftype[i] = flit_type[3*i +: 3];
      flen[i]  = length[LEN_W*i +: LEN_W];
      cand[i]  = req[i] && !empty[i] && (flit_type[3*i +: 3] == HDR_TYPE);
    end
  end

  // Search starts just after the last owner, so the previous winner ranks last.
  always_comb begin
    int unsigned idx;
    idx    = 0;
    found  = 1'b0;
    winner = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx = (32'(ptr_q) + k) % N_REQ;
      if (!found && cand[idx[IDX_W-1:0]]) begin
        found  = 1'b1;
        winner = idx[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    len_gt1_d  = len_gt1_q;
    pkt_done_d = 1'b0;
    len_err_d  = len_err_q;
    own_gnt    = (state_q == LOCK) && dcts && !empty[owner_q] && req[owner_q];
    own_tail   = (ftype[owner_q] == TAIL_TYPE);
    last_flit  = own_gnt && ((cnt_q == LEN_W'(1)) || own_tail);
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d   = LOCK;
          owner_d   = winner;
          cnt_d     = (flen[winner] == '0) ? LEN_W'(1) : flen[winner];
          len_gt1_d = (flen[winner] > LEN_W'(1));
        end
      end
      LOCK: begin
        if (own_gnt && own_tail && (cnt_q > LEN_W'(1))) begin
          len_err_d = 1'b1;
        end
        if (own_gnt && (cnt_q == LEN_W'(1)) && !own_tail && len_gt1_q) begin
          len_err_d = 1'b1;
        end
        if (last_flit) begin
          state_d    = IDLE;
          ptr_d      = owner_q;
          pkt_done_d = 1'b1;
          cnt_d      = '0;
        end else if (own_gnt) begin
          cnt_d = cnt_q - LEN_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant = '0;
    sel   = '0;
    if (state_q == LOCK) begin
      sel[owner_q]   = 1'b1;
      grant[owner_q] = own_gnt;
    end
  end

  assign busy     = (state_q == LOCK);
  assign pkt_done = pkt_done_q;
  assign len_err  = len_err_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      ptr_q      <= IDX_W'(N_REQ - 1);
      cnt_q      <= '0;
      len_gt1_q  <= 1'b0;
      pkt_done_q <= 1'b0;
      len_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      len_gt1_q  <= len_gt1_d;
      pkt_done_q <= pkt_done_d;
      len_err_q  <= len_err_d;
    end
  end

endmodule
